stream_demux_1xn: RTL and testbench

- Registered, parametrised 1-to-N demultiplexer with a valid/ready handshake on every port; successor to the combinational 2x1/1x4 demux cells.
- Routes each accepted input word to the output channel picked by in_sel. Each channel has a one-entry output register, so one channel stalling never blocks traffic to the other channels.
- Sits between a single producer and N independent consumers, such as lab peripherals or display lanes.

---
 rtl/stream_demux_pkg.sv | 13 +
 rtl/demux_chan_reg.sv | 37 +++
 rtl/stream_demux_1xn.sv | 94 +++++++++
 tb/tb_stream_demux_1xn.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// Shared constants and helpers for the registered 1-to-N stream demultiplexer.
package stream_demux_pkg;

    localparam int unsigned DEFAULT_W    = 8;
    localparam int unsigned DEFAULT_N    = 4;
    localparam int unsigned DROP_CNT_MAX = 255;

    // Minimum select width able to address n channels.
    function automatic int unsigned min_sel_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// One-entry output register for a single demux channel with valid/ready handshake.
module demux_chan_reg
    import stream_demux_pkg::*;
#(
    parameter int unsigned W = DEFAULT_W
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_ld_data,
    input  logic         i_out_ready,
    output logic         o_out_valid,
    output logic [W-1:0] o_out_data,
    output logic         o_can_load
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // A full slot may be reloaded in the same cycle its word drains.
    assign o_can_load  = !r_valid || i_out_ready;
    assign o_out_valid = r_valid;
    assign o_out_data  = r_data;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_ld_data;
        end else if (i_out_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux_1xn.sv
// Registered 1-to-N valid/ready demultiplexer with out-of-range drop counting.
// Optional broadcast input enabled by defining STREAM_DEMUX_BCAST_EN.
module stream_demux_1xn
    import stream_demux_pkg::*;
#(
    parameter int unsigned W     = DEFAULT_W,
    parameter int unsigned N     = DEFAULT_N,
    parameter int unsigned SEL_W = min_sel_w(DEFAULT_N)
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [W-1:0]   i_in_data,
    input  logic [SEL_W-1:0] i_in_sel,
    input  logic           i_in_valid,
`ifdef STREAM_DEMUX_BCAST_EN
    input  logic           i_in_bcast,
`endif
    output logic           o_in_ready,
    output logic [N*W-1:0] o_out_data,
    output logic [N-1:0]   o_out_valid,
    input  logic [N-1:0]   i_out_ready,
    output logic           o_drop_err,
    output logic [7:0]     o_drop_cnt
);

    logic [N-1:0] w_can_load;
    logic [N-1:0] w_load;
    logic         w_sel_in_range;
    logic         w_sel_ready;
    logic         w_accept;
    logic         w_drop;
    logic         r_drop_err;
    logic [7:0]   r_drop_cnt;

    always_comb begin
        w_sel_in_range = (32'(i_in_sel) < N);
        w_sel_ready    = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (32'(i_in_sel) == k) begin
                w_sel_ready = w_can_load[k];
            end
        end
        // Out-of-range words are always consumed so they can be discarded.
        o_in_ready = w_sel_in_range ? w_sel_ready : 1'b1;
`ifdef STREAM_DEMUX_BCAST_EN
        if (i_in_bcast) begin
            o_in_ready = &w_can_load;
        end
`endif
        w_accept = i_in_valid && o_in_ready;
        w_load   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_load[k] = w_accept && (32'(i_in_sel) == k);
        end
        w_drop = w_accept && !w_sel_in_range;
`ifdef STREAM_DEMUX_BCAST_EN
        if (i_in_bcast) begin
            w_load = {N{w_accept}};
            w_drop = 1'b0;
        end
`endif
    end

    for (genvar g = 0; g < N; g++) begin : g_chan
        demux_chan_reg #(
            .W (W)
        ) u_chan (
            .i_clk       (i_clk),
            .i_rst_n     (i_rst_n),
            .i_load      (w_load[g]),
            .i_ld_data   (i_in_data),
            .i_out_ready (i_out_ready[g]),
            .o_out_valid (o_out_valid[g]),
            .o_out_data  (o_out_data[g*W +: W]),
            .o_can_load  (w_can_load[g])
        );
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_drop_err <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_drop_err <= w_drop;
            if (w_drop && (r_drop_cnt != 8'(DROP_CNT_MAX))) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign o_drop_err = r_drop_err;
    assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Self-checking bench: N=4 instance for routing/backpressure, N=3 instance for drops.
module tb_stream_demux_1xn;

    logic        clk;
    logic        rst_n;

    logic [7:0]  a_data;
    logic [1:0]  a_sel;
    logic        a_valid;
    logic        a_bcast;
    logic        a_in_ready;
    logic [31:0] a_out_data;
    logic [3:0]  a_out_valid;
    logic [3:0]  a_out_ready;
    logic        a_drop_err;
    logic [7:0]  a_drop_cnt;

    logic [7:0]  b_data;
    logic [1:0]  b_sel;
    logic        b_valid;
    logic        b_in_ready;
    logic [23:0] b_out_data;
    logic [2:0]  b_out_valid;
    logic [2:0]  b_out_ready;
    logic        b_drop_err;
    logic [7:0]  b_drop_cnt;

    int n_checks;
    int n_errors;
    logic [7:0] sb_q [4][$];

    stream_demux_1xn #(.W(8), .N(4), .SEL_W(2)) u_dut_a (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_data   (a_data),
        .i_in_sel    (a_sel),
        .i_in_valid  (a_valid),
`ifdef STREAM_DEMUX_BCAST_EN
        .i_in_bcast  (a_bcast),
`endif
        .o_in_ready  (a_in_ready),
        .o_out_data  (a_out_data),
        .o_out_valid (a_out_valid),
        .i_out_ready (a_out_ready),
        .o_drop_err  (a_drop_err),
        .o_drop_cnt  (a_drop_cnt)
    );

    stream_demux_1xn #(.W(8), .N(3), .SEL_W(2)) u_dut_b (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_data   (b_data),
        .i_in_sel    (b_sel),
        .i_in_valid  (b_valid),
`ifdef STREAM_DEMUX_BCAST_EN
        .i_in_bcast  (1'b0),
`endif
        .o_in_ready  (b_in_ready),
        .o_out_data  (b_out_data),
        .o_out_valid (b_out_valid),
        .i_out_ready (b_out_ready),
        .o_drop_err  (b_drop_err),
        .o_drop_cnt  (b_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop on each output transfer, push on each accepted input.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) sb_q[k].delete();
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (a_out_valid[k] && a_out_ready[k]) begin
                    if (sb_q[k].size() == 0)
                        check("sb_word_expected", 32'(sb_q[k].size()), 32'd1);
                    else
                        check("sb_deliver", 32'(a_out_data[k*8 +: 8]), 32'(sb_q[k].pop_front()));
                end
            end
            if (a_valid && a_in_ready) begin
                if (a_bcast) begin
                    for (int k = 0; k < 4; k++) sb_q[k].push_back(a_data);
                end else begin
                    sb_q[a_sel].push_back(a_data);
                end
            end
        end
    end

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        a_data      = 8'hFF;
        a_sel       = 2'd0;
        a_valid     = 1'b1;
        a_bcast     = 1'b0;
        a_out_ready = 4'hF;
        b_data      = 8'hFF;
        b_sel       = 2'd3;
        b_valid     = 1'b1;
        b_out_ready = 3'h7;

        // Reset with traffic present
        tick();
        tick();
        check("rst_a_valid", 32'(a_out_valid), 32'h0);
        check("rst_a_data", a_out_data, 32'h0);
        check("rst_a_cnt", 32'(a_drop_cnt), 32'h0);
        check("rst_b_valid", 32'(b_out_valid), 32'h0);
        check("rst_b_cnt", 32'(b_drop_cnt), 32'h0);
        check("rst_b_err", 32'(b_drop_err), 32'h0);
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst_n   = 1'b1;
        #1;
        check("rst_in_ready", 32'(a_in_ready), 32'h1);

        // Routing to each channel on consecutive cycles
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1;
            a_sel   = 2'(i);
            a_data  = 8'hA0 + 8'(i);
            #1;
            check("route_ready", 32'(a_in_ready), 32'h1);
            tick();
            check("route_valid", 32'(a_out_valid[i]), 32'h1);
            check("route_data", 32'(a_out_data[i*8 +: 8]), 32'(8'hA0 + 8'(i)));
        end
        a_valid = 1'b0;
        tick();
        check("route_drained", 32'(a_out_valid), 32'h0);

        // Backpressure on channel 2
        a_out_ready = 4'b1011;
        a_valid = 1'b1; a_sel = 2'd2; a_data = 8'h11;
        tick();
        check("bp_first_loaded", 32'(a_out_data[23:16]), 32'h11);
        a_data = 8'h22;
        #1;
        check("bp_ready_low", 32'(a_in_ready), 32'h0);
        tick();
        check("bp_hold_valid", 32'(a_out_valid[2]), 32'h1);
        check("bp_hold_data", 32'(a_out_data[23:16]), 32'h11);
        a_sel = 2'd1; a_data = 8'h33;
        #1;
        check("bp_ch1_ready", 32'(a_in_ready), 32'h1);
        tick();
        check("bp_ch1_data", 32'(a_out_data[15:8]), 32'h33);
        check("bp_ch2_still", 32'(a_out_data[23:16]), 32'h11);
        a_sel = 2'd2; a_data = 8'h22;
        #1;
        check("bp_ready_low2", 32'(a_in_ready), 32'h0);
        a_out_ready = 4'hF;
        #1;
        check("bp_release_ready", 32'(a_in_ready), 32'h1);
        tick();
        check("bp_swap_valid", 32'(a_out_valid[2]), 32'h1);
        check("bp_swap_data", 32'(a_out_data[23:16]), 32'h22);
        a_valid = 1'b0;
        tick();
        check("bp_drained", 32'(a_out_valid), 32'h0);

        // Out-of-range drop on the N=3 instance
        b_valid = 1'b1; b_sel = 2'd3; b_data = 8'h5A;
        #1;
        check("oor_ready", 32'(b_in_ready), 32'h1);
        tick();
        b_valid = 1'b0;
        check("oor_err", 32'(b_drop_err), 32'h1);
        check("oor_cnt", 32'(b_drop_cnt), 32'h1);
        check("oor_no_valid", 32'(b_out_valid), 32'h0);
        tick();
        check("oor_err_pulse", 32'(b_drop_err), 32'h0);
        check("oor_cnt_hold", 32'(b_drop_cnt), 32'h1);
        b_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 99) begin
                check("oor_err_b2b", 32'(b_drop_err), 32'h1);
                check("oor_cnt_101", 32'(b_drop_cnt), 32'd101);
            end
        end
        b_valid = 1'b0;
        tick();
        check("oor_cnt_sat", 32'(b_drop_cnt), 32'd255);
        check("oor_sat_no_valid", 32'(b_out_valid), 32'h0);

        // Mid-operation reset discards buffered words
        a_out_ready = 4'h0;
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1; a_sel = 2'(i); a_data = 8'hB0 + 8'(i);
            tick();
        end
        a_valid = 1'b0;
        check("mid_full", 32'(a_out_valid), 32'hF);
        check("mid_data", a_out_data, 32'hB3B2B1B0);
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", 32'(a_out_valid), 32'h0);
        check("mid_rst_data", a_out_data, 32'h0);
        check("mid_rst_cnt", 32'(b_drop_cnt), 32'h0);
        rst_n = 1'b1;
        a_out_ready = 4'hF;
        tick();
        tick();
        check("mid_no_delivery", 32'(a_out_valid), 32'h0);

`ifdef STREAM_DEMUX_BCAST_EN
        // Broadcast blocked by a stalled channel, then released
        a_out_ready = 4'b1110;
        a_valid = 1'b1; a_sel = 2'd0; a_data = 8'h77;
        tick();
        a_bcast = 1'b1; a_data = 8'h3C; a_sel = 2'd3;
        #1;
        check("bc_ready_low", 32'(a_in_ready), 32'h0);
        tick();
        check("bc_hold", 32'(a_out_data[7:0]), 32'h77);
        check("bc_no_load", 32'(a_out_valid), 32'h1);
        a_out_ready = 4'hF;
        #1;
        check("bc_ready_high", 32'(a_in_ready), 32'h1);
        tick();
        a_valid = 1'b0;
        a_bcast = 1'b0;
        check("bc_valid", 32'(a_out_valid), 32'hF);
        check("bc_data", a_out_data, 32'h3C3C3C3C);
        check("bc_no_drop", 32'(a_drop_err), 32'h0);
        tick();
        tick();
`endif

        check("sb_empty", 32'(sb_q[0].size() + sb_q[1].size() + sb_q[2].size() + sb_q[3].size()),
              32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
